multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction, and drives the immediate-select, ALU-operand, PC and register-file enables.
- Owns the memory request handshake, including a request timeout.
- Traps on illegal opcodes or a memory timeout.

---
 rtl/multicycle_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I datapath: sequences fetch/decode/execute/memory/writeback,
// owns the memory request handshake with a timeout, and traps on illegal opcodes or timeouts.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_fetch,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_LOAD, C_OPIMM, C_OP, C_STORE, C_BRANCH,
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILLEGAL
    } cls_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cls_t             cls;
    logic             wait_expired;
    logic             unused_inst;

    assign unused_inst  = ^inst[31:7];
    assign wait_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign state        = state_q;

    always_comb begin
        cls = C_ILLEGAL;
        case (inst[6:0])
            7'b0000011: cls = C_LOAD;
            7'b0010011: cls = C_OPIMM;
            7'b0110011: cls = C_OP;
            7'b0100011: cls = C_STORE;
            7'b1100011: cls = C_BRANCH;
            7'b0110111: cls = C_LUI;
            7'b0010111: cls = C_AUIPC;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            default:    cls = C_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        alu_op       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        retire       = 1'b0;
        trap         = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: state_d = (cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_OP: begin
                        alu_op  = 2'd1;
                        state_d = S_WB;
                    end
                    C_OPIMM: begin
                        alu_b_sel = 1'b1;
                        alu_op    = 2'd1;
                        state_d   = S_WB;
                    end
                    C_LUI: begin
                        alu_a_sel = 2'd2;
                        alu_b_sel = 1'b1;
                        state_d   = S_WB;
                    end
                    C_AUIPC: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                        state_d   = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_b_sel = 1'b1;
                        state_d   = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = br_taken ? 2'd1 : 2'd0;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    C_JAL: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = 2'd1;
                        rf_we     = 1'b1;
                        wb_sel    = 2'd2;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    C_JALR: begin
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = 2'd2;
                        rf_we     = 1'b1;
                        wb_sel    = 2'd2;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                // address operands stay on rs1+imm until the request completes
                mem_req   = 1'b1;
                mem_we    = (cls == C_STORE);
                alu_b_sel = 1'b1;
                if (mem_ready) begin
                    if (cls == C_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = (cls == C_LOAD) ? 2'd1 : 2'd0;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: builds an expected per-cycle trace from instruction
// class and memory latencies, drives it into the DUT and compares state and all outputs.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    localparam int K_ILL = 0, K_LOAD = 1, K_OPIMM = 2, K_OP = 3, K_STORE = 4,
                   K_BRANCH = 5, K_LUI = 6, K_AUIPC = 7, K_JAL = 8, K_JALR = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_is_fetch, ir_we, pc_we, alu_b_sel, rf_we, retire, trap;
    logic [1:0]  pc_sel, alu_a_sel, alu_op, wb_sel;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;
    int obs_ret = 0;
    int exp_ret = 0;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire), .trap(trap),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in;
        logic        mr;
        logic        bt;
        logic [2:0]  st;
        logic [16:0] o;
    } step_t;

    step_t plan[$];

    function automatic logic [16:0] ov(input logic mreq, input logic mwe, input logic mif,
                                       input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                       input logic [1:0] as, input logic bs, input logic [1:0] aop,
                                       input logic rfwe, input logic [1:0] wbs, input logic ret,
                                       input logic trp);
        return {mreq, mwe, mif, irwe, pcwe, pcs, as, bs, aop, rfwe, wbs, ret, trp};
    endfunction

    function automatic logic [16:0] observed();
        return {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                alu_op, rf_we, wb_sel, retire, trap};
    endfunction

    function automatic int classify(input logic [6:0] opc);
        case (opc)
            7'b0000011: return K_LOAD;
            7'b0010011: return K_OPIMM;
            7'b0110011: return K_OP;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BRANCH;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            default:    return K_ILL;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] in, input logic mr, input logic bt,
                        input logic [2:0] st, input logic [16:0] o);
        step_t s;
        s.in = in; s.mr = mr; s.bt = bt; s.st = st; s.o = o;
        plan.push_back(s);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_trap(input logic [31:0] in, input int n);
        for (int i = 0; i < n; i++)
            push(in, rbit(), rbit(), 3'd6, ov(0,0,0,0,0,2'd0,2'd0,0,2'd0,0,2'd0,0,1));
    endtask

    // lf/lm: wait cycle (1..TIMEOUT) on which mem_ready arrives; 0 means it never does.
    task automatic plan_instr(input logic [31:0] in, input int lf, input int lm, input logic bt,
                              output bit completes);
        int k, nf, nm;
        logic mr, st;
        k  = classify(in[6:0]);
        completes = 1'b0;
        nf = (lf == 0) ? TIMEOUT : lf;
        for (int c = 1; c <= nf; c++) begin
            mr = (lf != 0) && (c == lf);
            push(in, mr, rbit(), 3'd1, ov(1,0,1,mr,0,2'd0,2'd0,0,2'd0,0,2'd0,0,0));
        end
        if (lf == 0) begin push_trap(in, 3); return; end
        push(in, rbit(), rbit(), 3'd2, '0);
        if (k == K_ILL) begin push_trap(in, 22); return; end
        case (k)
            K_OP:     push(in, rbit(), bt, 3'd3, ov(0,0,0,0,0,2'd0,2'd0,0,2'd1,0,2'd0,0,0));
            K_OPIMM:  push(in, rbit(), bt, 3'd3, ov(0,0,0,0,0,2'd0,2'd0,1,2'd1,0,2'd0,0,0));
            K_LUI:    push(in, rbit(), bt, 3'd3, ov(0,0,0,0,0,2'd0,2'd2,1,2'd0,0,2'd0,0,0));
            K_AUIPC:  push(in, rbit(), bt, 3'd3, ov(0,0,0,0,0,2'd0,2'd1,1,2'd0,0,2'd0,0,0));
            K_LOAD, K_STORE:
                      push(in, rbit(), bt, 3'd3, ov(0,0,0,0,0,2'd0,2'd0,1,2'd0,0,2'd0,0,0));
            K_BRANCH: push(in, rbit(), bt, 3'd3, ov(0,0,0,0,1,{1'b0,bt},2'd1,1,2'd0,0,2'd0,1,0));
            K_JAL:    push(in, rbit(), bt, 3'd3, ov(0,0,0,0,1,2'd1,2'd1,1,2'd0,1,2'd2,1,0));
            default:  push(in, rbit(), bt, 3'd3, ov(0,0,0,0,1,2'd2,2'd0,1,2'd0,1,2'd2,1,0));
        endcase
        if (k == K_BRANCH || k == K_JAL || k == K_JALR) begin completes = 1'b1; return; end
        if (k == K_LOAD || k == K_STORE) begin
            st = (k == K_STORE);
            nm = (lm == 0) ? TIMEOUT : lm;
            for (int c = 1; c <= nm; c++) begin
                mr = (lm != 0) && (c == lm);
                push(in, mr, rbit(), 3'd4,
                     ov(1,st,0,0,mr & st,2'd0,2'd0,1,2'd0,0,2'd0,mr & st,0));
            end
            if (lm == 0) begin push_trap(in, 3); return; end
            if (st) begin completes = 1'b1; return; end
        end
        push(in, rbit(), rbit(), 3'd5,
             ov(0,0,0,0,1,2'd0,2'd0,0,2'd0,1,(k == K_LOAD) ? 2'd1 : 2'd0,1,0));
        completes = 1'b1;
    endtask

    task automatic run_plan(input string tag, input int n);
        step_t s;
        int i;
        i = 0;
        while (plan.size() > 0 && i < n) begin
            s = plan.pop_front();
            @(negedge clk);
            inst = s.in; mem_ready = s.mr; br_taken = s.bt;
            #1;
            check($sformatf("%s[%0d].state", tag, i), 32'(state), 32'(s.st));
            check($sformatf("%s[%0d].outs", tag, i), 32'(observed()), 32'(s.o));
            if (retire) obs_ret++;
            i++;
        end
        plan.delete();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".async_state"}, 32'(state), 32'd0);
        check({tag, ".async_outs"}, 32'(observed()), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check({tag, ".rel_state"}, 32'(state), 32'd0);
        check({tag, ".rel_outs"}, 32'(observed()), 32'd0);
    endtask

    task automatic instr(input string tag, input logic [31:0] in, input int lf, input int lm,
                         input logic bt);
        bit ok;
        plan_instr(in, lf, lm, bt, ok);
        if (ok) exp_ret++;
        run_plan(tag, 1000);
        if (!ok) do_reset({tag, ".rst"});
    endtask

    logic [31:0] legal_ops[9] = '{32'h03, 32'h13, 32'h33, 32'h23, 32'h63,
                                  32'h37, 32'h17, 32'h6F, 32'h67};

    initial begin
        logic [31:0] r, in;
        logic [6:0]  opc;
        bit          ok;
        do_reset("por");

        instr("addi",  32'h00500093, 1, 0, 1'b0);
        instr("lw",    32'h0000A103, 1, 4, 1'b0);
        instr("beq_t", 32'h00000463, 2, 0, 1'b1);
        instr("beq_n", 32'h00000463, 1, 0, 1'b0);
        instr("jalr",  32'h000080E7, 3, 0, 1'b0);
        instr("sw",    32'h0020A023, 1, 2, 1'b0);
        instr("fetch_last", 32'h00500093, TIMEOUT, 0, 1'b0);
        instr("mem_last",   32'h0000A103, 1, TIMEOUT, 1'b0);
        instr("illegal", 32'h00000000, 1, 0, 1'b0);
        instr("fetch_to", 32'h00500093, 0, 0, 1'b0);
        instr("mem_to",   32'h0020A023, 1, 0, 1'b0);

        // abort a load mid-MEM: no retire, outputs fall with rst_n
        plan_instr(32'h0000A103, 1, 0, 1'b0, ok);
        run_plan("mid_mem", 6);
        check("mid_mem.req_before", 32'(mem_req), 32'd1);
        do_reset("mid_mem.rst");

        for (int n = 0; n < 60; n++) begin
            r = $urandom();
            in = r;
            if ($urandom_range(0, 9) == 0) begin
                do begin opc = 7'($urandom()); end while (classify(opc) != K_ILL);
                in[6:0] = opc;
            end else begin
                in[6:0] = legal_ops[$urandom_range(0, 8)][6:0];
            end
            case ($urandom_range(0, 19))
                0:       instr($sformatf("rnd%0d", n), in, 0, 0, rbit());
                1:       instr($sformatf("rnd%0d", n), in, $urandom_range(1, 3), 0, rbit());
                default: instr($sformatf("rnd%0d", n), in, $urandom_range(1, TIMEOUT),
                               ($urandom_range(0, 3) == 0) ? TIMEOUT : $urandom_range(1, 5),
                               rbit());
            endcase
        end

        check("retire_count", 32'(obs_ret), 32'(exp_ret));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
